// File: rtl/common_pkg.sv
// Shared bus types for the core-to-memory arbiter.
// Fetch and data port types are consumed unchanged by the arbiter.
package common;

    localparam logic [1:0] MSIZE_WORD = 2'd2;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic        is_write;
    } mem_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } mem_resp_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_I,
        S_REQ_D,
        S_WAIT_I,
        S_WAIT_D
    } arb_state_e;

endpackage

// File: rtl/core_bus_arbiter.sv
// Muxes fetch and data requests onto one memory port, one transaction at a time.
// Data wins ties until a run of data grants starves a waiting fetch.
module core_bus_arbiter
    import common::*;
#(
    parameter int IFETCH_STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output mem_req_t   mreq,
    input  logic       mreq_ready,
    input  mem_resp_t  mresp,
    output logic       proto_err
);

    localparam int CW = $clog2(IFETCH_STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(IFETCH_STARVE_LIMIT);

    arb_state_e    state_q, state_d;
    mem_req_t      hold_q, hold_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          starved;
    logic          in_wait;

    assign starved = ireq.valid && (starve_q == LIMIT);
    assign in_wait = (state_q == S_WAIT_I) || (state_q == S_WAIT_D);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            hold_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        starve_d  = starve_q;
        mreq      = '0;
        iresp     = '0;
        dresp     = '0;
        proto_err = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (dreq.valid && !starved) begin
                    hold_d = '{valid:    1'b1,
                               addr:     dreq.addr,
                               size:     dreq.size,
                               strobe:   dreq.strobe,
                               data:     dreq.data,
                               is_write: |dreq.strobe};
                    if (!ireq.valid)
                        starve_d = '0;
                    else if (starve_q != LIMIT)
                        starve_d = starve_q + 1'b1;
                    state_d = S_REQ_D;
                end else if (ireq.valid) begin
                    hold_d = '{valid:    1'b1,
                               addr:     ireq.addr,
                               size:     MSIZE_WORD,
                               strobe:   4'h0,
                               data:     32'h0,
                               is_write: 1'b0};
                    starve_d = '0;
                    state_d  = S_REQ_I;
                end
            end
            S_REQ_I: begin
                mreq = hold_q;
                if (mreq_ready) begin
                    iresp.addr_ok = 1'b1;
                    state_d       = S_WAIT_I;
                end
            end
            S_REQ_D: begin
                mreq = hold_q;
                if (mreq_ready) begin
                    dresp.addr_ok = 1'b1;
                    state_d       = S_WAIT_D;
                end
            end
            S_WAIT_I: begin
                if (mresp.valid) begin
                    iresp.data_ok = 1'b1;
                    iresp.data    = mresp.data;
                    state_d       = S_IDLE;
                end
            end
            S_WAIT_D: begin
                if (mresp.valid) begin
                    dresp.data_ok = 1'b1;
                    dresp.data    = mresp.data;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Gated by reset so a stray response during reset stays silent.
        proto_err = rst && mresp.valid && !in_wait;
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level model.
module tb_core_bus_arbiter;
    import common::*;

    localparam int LIMIT = 4;
    typedef logic [127:0] w_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    mem_req_t   mreq;
    logic       mreq_ready;
    mem_resp_t  mresp;
    logic       proto_err;

    int checks = 0;
    int passes = 0;

    core_bus_arbiter #(.IFETCH_STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .ireq       (ireq),
        .iresp      (iresp),
        .dreq       (dreq),
        .dresp      (dresp),
        .mreq       (mreq),
        .mreq_ready (mreq_ready),
        .mresp      (mresp),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input w_t got, input w_t exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ireq       = '0;
        dreq       = '0;
        mresp      = '0;
        mreq_ready = 1'b0;
    endtask

    // Transaction model: at most one transaction, either not yet
    // accepted downstream or accepted and awaiting its response.
    bit       m_have  = 0;
    bit       m_acc   = 0;
    bit       m_fetch = 0;
    mem_req_t m_txn   = '0;
    int       m_starve = 0;

    always @(negedge clk) begin
        mem_req_t   e_mreq;
        ibus_resp_t e_i;
        dbus_resp_t e_d;
        logic       e_pe;
        bit         starved;
        e_mreq = '0;
        e_i    = '0;
        e_d    = '0;
        e_pe   = 1'b0;
        if (rst) begin
            if (m_have && !m_acc) begin
                e_mreq = m_txn;
                if (mreq_ready) begin
                    if (m_fetch) e_i.addr_ok = 1'b1;
                    else e_d.addr_ok = 1'b1;
                end
            end
            if (m_have && m_acc && mresp.valid) begin
                if (m_fetch) begin
                    e_i.data_ok = 1'b1;
                    e_i.data    = mresp.data;
                end else begin
                    e_d.data_ok = 1'b1;
                    e_d.data    = mresp.data;
                end
            end
            e_pe = mresp.valid && !(m_have && m_acc);
        end
        chk("model_mreq", w_t'(mreq), w_t'(e_mreq));
        chk("model_iresp", w_t'(iresp), w_t'(e_i));
        chk("model_dresp", w_t'(dresp), w_t'(e_d));
        chk("model_proto_err", w_t'(proto_err), w_t'(e_pe));
        if (!rst) begin
            m_have   = 0;
            m_acc    = 0;
            m_starve = 0;
        end else if (!m_have) begin
            starved = ireq.valid && (m_starve >= LIMIT);
            if (dreq.valid && !starved) begin
                m_have  = 1;
                m_acc   = 0;
                m_fetch = 0;
                m_txn   = '{valid: 1'b1, addr: dreq.addr, size: dreq.size,
                            strobe: dreq.strobe, data: dreq.data,
                            is_write: (dreq.strobe != 4'h0)};
                if (!ireq.valid) m_starve = 0;
                else if (m_starve < LIMIT) m_starve = m_starve + 1;
            end else if (ireq.valid) begin
                m_have   = 1;
                m_acc    = 0;
                m_fetch  = 1;
                m_txn    = '{valid: 1'b1, addr: ireq.addr, size: MSIZE_WORD,
                             strobe: 4'h0, data: 32'h0, is_write: 1'b0};
                m_starve = 0;
            end
        end else if (!m_acc) begin
            if (mreq_ready) m_acc = 1;
        end else if (mresp.valid) begin
            m_have = 0;
        end
    end

    initial begin
        mem_req_t e;
        logic [5:0] seq;
        int n;

        // Reset with live inputs: everything must stay quiet.
        idle_in();
        ireq  = '{valid: 1'b1, addr: 32'h8000_0000};
        mresp = '{valid: 1'b1, data: 32'hFFFF_FFFF};
        mreq_ready = 1'b1;
        nxt();
        @(negedge clk);
        chk("reset_mreq", w_t'(mreq), w_t'(0));
        chk("reset_iresp", w_t'(iresp), w_t'(0));
        chk("reset_dresp", w_t'(dresp), w_t'(0));
        chk("reset_proto_err", w_t'(proto_err), w_t'(0));
        nxt();
        idle_in();
        rst = 1'b1;
        nxt();

        // Data write: addr_ok on cycle 2, data_ok on cycle 3.
        dreq = '{valid: 1'b1, addr: 32'h8000_0010, size: MSIZE_WORD,
                 strobe: 4'hF, data: 32'hDEAD_BEEF};
        mreq_ready = 1'b1;
        @(negedge clk);
        chk("wr_c1_no_mreq", w_t'(mreq.valid), w_t'(0));
        nxt();
        dreq.valid = 1'b0;
        e = '{valid: 1'b1, addr: 32'h8000_0010, size: MSIZE_WORD,
              strobe: 4'hF, data: 32'hDEAD_BEEF, is_write: 1'b1};
        @(negedge clk);
        chk("wr_c2_mreq", w_t'(mreq), w_t'(e));
        chk("wr_c2_addr_ok", w_t'(dresp.addr_ok), w_t'(1));
        nxt();
        mresp = '{valid: 1'b1, data: 32'h1234_5678};
        @(negedge clk);
        chk("wr_c3_data_ok", w_t'(dresp.data_ok), w_t'(1));
        chk("wr_c3_data", w_t'(dresp.data), w_t'(32'h1234_5678));
        chk("wr_c3_i_quiet", w_t'(iresp), w_t'(0));
        nxt();
        idle_in();
        @(negedge clk);
        chk("wr_c4_quiet", w_t'(dresp), w_t'(0));
        nxt();

        // Simultaneous fetch and data: data first, fetch after a bubble.
        ireq = '{valid: 1'b1, addr: 32'h8000_0000};
        dreq = '{valid: 1'b1, addr: 32'h0000_0100, size: MSIZE_WORD,
                 strobe: 4'h0, data: 32'h0};
        mreq_ready = 1'b1;
        nxt();
        dreq.valid = 1'b0;
        @(negedge clk);
        chk("tie_d_first", w_t'(mreq.addr), w_t'(32'h0000_0100));
        chk("tie_d_addr_ok", w_t'(dresp.addr_ok), w_t'(1));
        chk("tie_i_not_ok", w_t'(iresp.addr_ok), w_t'(0));
        nxt();
        mresp = '{valid: 1'b1, data: 32'hA5A5_0001};
        @(negedge clk);
        chk("tie_d_data_ok", w_t'(dresp.data_ok), w_t'(1));
        nxt();
        mresp = '0;
        @(negedge clk);
        chk("tie_bubble", w_t'(mreq.valid), w_t'(0));
        nxt();
        e = '{valid: 1'b1, addr: 32'h8000_0000, size: MSIZE_WORD,
              strobe: 4'h0, data: 32'h0, is_write: 1'b0};
        @(negedge clk);
        chk("tie_i_mreq", w_t'(mreq), w_t'(e));
        chk("tie_i_addr_ok", w_t'(iresp.addr_ok), w_t'(1));
        nxt();
        ireq.valid = 1'b0;
        mresp = '{valid: 1'b1, data: 32'hC0DE_0002};
        @(negedge clk);
        chk("tie_i_resp", w_t'(iresp),
            w_t'(ibus_resp_t'{addr_ok: 1'b0, data_ok: 1'b1, data: 32'hC0DE_0002}));
        nxt();
        idle_in();
        nxt();

        // Starvation: fetch held, data streaming, limit 4.
        ireq  = '{valid: 1'b1, addr: 32'h8000_0000};
        dreq  = '{valid: 1'b1, addr: 32'h0000_0200, size: MSIZE_WORD,
                  strobe: 4'h3, data: 32'h55};
        mresp = '{valid: 1'b1, data: 32'h77};
        mreq_ready = 1'b1;
        seq = '0;
        n = 0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (mreq.valid && mreq_ready) begin
                seq = {seq[4:0], mreq.is_write};
                n++;
            end
            nxt();
        end
        idle_in();
        chk("starve_order", w_t'(seq), w_t'(6'b111101));
        chk("starve_grants", w_t'(n), w_t'(6));
        chk("model_starve_after", w_t'(m_starve), w_t'(1));
        nxt();

        // Downstream stall in REQ_I: fields stable, addr_ok only on accept.
        ireq = '{valid: 1'b1, addr: 32'h8000_0040};
        nxt();
        ireq.valid = 1'b0;
        e = '{valid: 1'b1, addr: 32'h8000_0040, size: MSIZE_WORD,
              strobe: 4'h0, data: 32'h0, is_write: 1'b0};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk("stall_mreq", w_t'(mreq), w_t'(e));
            chk("stall_no_addr_ok", w_t'(iresp.addr_ok), w_t'(0));
            nxt();
        end
        mreq_ready = 1'b1;
        @(negedge clk);
        chk("stall_accept", w_t'(iresp.addr_ok), w_t'(1));
        nxt();
        mreq_ready = 1'b0;
        mresp = '{valid: 1'b1, data: 32'h0BAD_F00D};
        @(negedge clk);
        chk("stall_data", w_t'(iresp.data), w_t'(32'h0BAD_F00D));
        nxt();
        idle_in();
        nxt();

        // Stray response in IDLE.
        mresp = '{valid: 1'b1, data: 32'h1111_2222};
        @(negedge clk);
        chk("stray_proto_err", w_t'(proto_err), w_t'(1));
        chk("stray_no_i_ok", w_t'(iresp.data_ok), w_t'(0));
        chk("stray_no_d_ok", w_t'(dresp.data_ok), w_t'(0));
        nxt();
        mresp = '0;
        ireq = '{valid: 1'b1, addr: 32'h8000_0080};
        mreq_ready = 1'b1;
        @(negedge clk);
        chk("stray_pulse_once", w_t'(proto_err), w_t'(0));
        nxt();
        ireq.valid = 1'b0;
        @(negedge clk);
        chk("stray_still_idle", w_t'(mreq.addr), w_t'(32'h8000_0080));
        nxt();
        mresp = '{valid: 1'b1, data: 32'h3};
        @(negedge clk);
        chk("stray_after_ok", w_t'(iresp.data_ok), w_t'(1));
        nxt();
        idle_in();
        nxt();

        // Reset during WAIT_D, then a clean fetch.
        dreq = '{valid: 1'b1, addr: 32'h0000_0300, size: MSIZE_WORD,
                 strobe: 4'h0, data: 32'h0};
        mreq_ready = 1'b1;
        nxt();
        dreq.valid = 1'b0;
        nxt();
        rst = 1'b0;
        mresp = '{valid: 1'b1, data: 32'h9999_9999};
        @(negedge clk);
        chk("rst_wait_dresp", w_t'(dresp), w_t'(0));
        chk("rst_wait_mreq", w_t'(mreq), w_t'(0));
        chk("rst_wait_proto", w_t'(proto_err), w_t'(0));
        nxt();
        rst = 1'b1;
        mresp = '0;
        ireq = '{valid: 1'b1, addr: 32'h8000_0100};
        nxt();
        ireq.valid = 1'b0;
        @(negedge clk);
        chk("rst_after_mreq", w_t'(mreq.addr), w_t'(32'h8000_0100));
        nxt();
        mresp = '{valid: 1'b1, data: 32'h4242_4242};
        @(negedge clk);
        chk("rst_after_data", w_t'(iresp.data), w_t'(32'h4242_4242));
        nxt();
        idle_in();
        nxt();

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst           = ($urandom_range(0, 299) != 0);
            ireq.valid    = ($urandom_range(0, 9) < 6);
            ireq.addr     = $urandom;
            dreq.valid    = ($urandom_range(0, 9) < 6);
            dreq.addr     = $urandom;
            dreq.size     = 2'($urandom_range(0, 2));
            dreq.strobe   = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            dreq.data     = $urandom;
            mreq_ready    = ($urandom_range(0, 1) != 0);
            mresp.valid   = ($urandom_range(0, 9) < 4);
            mresp.data    = $urandom;
            nxt();
        end
        rst = 1'b1;
        idle_in();
        nxt();
        nxt();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/core_bus_arbiter.md
CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

Interface
REQ-001 Parameter IFETCH_STARVE_LIMIT, default 4, SHALL set the number of consecutive data grants allowed while a fetch request waits.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 ireq  input  ibus_req_t  SHALL carry the core instruction-fetch request (valid, addr).
REQ-005 iresp  output  ibus_resp_t  SHALL carry addr_ok, data_ok and data back to the fetch stage.
REQ-006 dreq  input  dbus_req_t  SHALL carry the core data request (valid, addr, size, strobe, data).
REQ-007 dresp  output  dbus_resp_t  SHALL carry addr_ok, data_ok and data back to the memory stage.
REQ-008 mreq  output  mem_req_t  SHALL carry the downstream request (valid, addr, size, strobe, data, is_write).
REQ-009 mreq_ready  input  1  SHALL indicate that the downstream port accepts mreq this cycle.
REQ-010 mresp  input  mem_resp_t  SHALL carry the downstream response (valid, data).
REQ-011 proto_err  output  1  SHALL pulse for one cycle when mresp.valid arrives outside a WAIT state.

Function
REQ-012 The FSM SHALL have the states IDLE, REQ_I, REQ_D, WAIT_I and WAIT_D, with one transaction outstanding at most.
REQ-013 In IDLE with dreq.valid=1, the FSM SHALL latch dreq into the hold register and enter REQ_D, unless ireq.valid=1 and starve_cnt==IFETCH_STARVE_LIMIT.
REQ-014 In IDLE, REQ-013 SHALL not apply if its exception holds or dreq.valid=0; then, with ireq.valid=1, the FSM SHALL latch ireq, set is_write=0 and size=word, and enter REQ_I.
REQ-015 In REQ_x, mreq.valid SHALL be 1 and all mreq fields SHALL come only from the hold register, stable until acceptance.
REQ-016 On mreq.valid&mreq_ready in REQ_x, the matching addr_ok SHALL be 1 that cycle and the FSM SHALL enter WAIT_x.
REQ-017 In WAIT_x with mresp.valid=1, the matching data_ok SHALL be 1 that cycle, data SHALL equal mresp.data, and the FSM SHALL return to IDLE.
REQ-018 Minimum latency from request valid to data_ok SHALL be 3 cycles (grant, accept, response), plus one IDLE bubble between transactions.
REQ-019 mresp.valid in IDLE/REQ_x SHALL be ignored except that proto_err pulses and state is unchanged.
REQ-020 starve_cnt SHALL increment (saturating at IFETCH_STARVE_LIMIT) on each D grant with ireq.valid=1, and SHALL clear on an I grant or on a D grant with ireq.valid=0.
REQ-021 Deassertion of a core valid after the grant SHALL not cancel the latched transaction.
REQ-022 Outside the cycles in REQ-016/REQ-017, all addr_ok, data_ok and data outputs SHALL be 0.

Reset
REQ-023 While rst=0: state=IDLE, starve_cnt=0, hold register=0, mreq=0, iresp=0, dresp=0, proto_err=0.
REQ-024 Reset mid-transaction SHALL abandon the transaction without issuing a response; the downstream port SHALL share the same reset.

Structure
REQ-025 mem_req_t, mem_resp_t and the FSM state enum SHALL live in the shared package common; ibus/dbus types SHALL be reused from it unchanged.
REQ-026 The block SHALL be a single module with no sub-modules; the hold register and starve counter SHALL be inline.

Verification
REQ-027 dreq write addr=0x8000_0010, strobe=0x0F, data=0xDEAD_BEEF, mreq_ready=1, mresp one cycle later -> mreq matches; dresp.addr_ok at cycle 2; dresp.data_ok at cycle 3.
REQ-028 ireq addr=0x8000_0000 and dreq simultaneously, starve_cnt=0 -> data granted first; fetch issued after the data data_ok plus an IDLE bubble.
REQ-029 ireq held and 5 back-to-back dreqs with limit=4 -> grants D,D,D,D,I,D; starve_cnt clears to 0 on the I grant.
REQ-030 mreq_ready low for 7 cycles in REQ_I -> mreq fields constant for all 7 cycles; addr_ok only on the accept cycle.
REQ-031 mresp.valid pulsed in IDLE -> proto_err=1 for 1 cycle; no data_ok and state stays IDLE.
REQ-032 rst=0 asserted during WAIT_D -> all outputs 0 immediately; after release, a new ireq completes normally.
